or_gate_rr_sched: RTL and testbench

Round-robin scheduler that time-shares one single-gate OR element (the 74x32 gate model) among `N_REQ` requesters. It arbitrates requests, drives the gate inputs, waits a programmable settle time, captures the gate output and returns a one-bit result with a per-requester done pulse. It sits between requester logic and an external `MOD_74x32_1` instance, whose `A`, `B` and `Y` connect to `GATE_A`, `GATE_B` and `GATE_Y`.

---
 rtl/or_gate_rr_sched.sv | 149 ++++++++++++++
 tb/tb_or_gate_rr_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/or_gate_rr_sched.sv
// ============================================================================
//  Module   : or_gate_rr_sched
//  Purpose  : Round-robin scheduler time-sharing one external OR gate among
//             N_REQ requesters. Optional macro: OR_SCHED_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module or_gate_rr_sched #(
    parameter int N_REQ      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] req_a_i,
    input  logic [N_REQ-1:0] req_b_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] done_o,
    output logic             res_o,
    output logic             busy_o,
    output logic             gate_a_o,
    output logic             gate_b_o,
    input  logic             gate_y_i,
    output logic             err_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             res_q, res_d;
    logic             ga_q, ga_d;
    logic             gb_q, gb_d;
    logic             err_q, err_d;

    logic             any_req;
    logic [PTR_W-1:0] win_sel;
    logic [PTR_W-1:0] scan_idx;

    // Scan downward so the lowest offset from ptr (the rotating priority head) wins.
    always_comb begin
        any_req  = 1'b0;
        win_sel  = '0;
        scan_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (req_i[scan_idx]) begin
                any_req = 1'b1;
                win_sel = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = '0;
        res_d   = res_q;
        ga_d    = ga_q;
        gb_d    = gb_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    ga_d           = req_a_i[win_sel];
                    gb_d           = req_b_i[win_sel];
                    gnt_d[win_sel] = 1'b1;
                    win_d          = win_sel;
                    cnt_d          = CNT_W'(SETTLE_CYC - 1);
                    state_d        = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                res_d         = gate_y_i;
                done_d[win_q] = 1'b1;
                ptr_d         = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d       = S_IDLE;
`ifdef OR_SCHED_CHECK_EN
                if (gate_y_i != (ga_q | gb_q)) begin
                    err_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            res_q   <= 1'b0;
            ga_q    <= 1'b0;
            gb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            ga_q    <= ga_d;
            gb_q    <= gb_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign res_o    = res_q;
    assign gate_a_o = ga_q;
    assign gate_b_o = gb_q;
    assign busy_o   = (state_q == S_SETTLE) || (state_q == S_CAPTURE);

`ifdef OR_SCHED_CHECK_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_or_gate_rr_sched.sv
// ============================================================================
//  Module   : tb_or_gate_rr_sched
//  Purpose  : Self-checking bench for or_gate_rr_sched against a
//             transaction-timing reference model. Honours OR_SCHED_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_or_gate_rr_sched;

    localparam int N_REQ      = 4;
    localparam int SETTLE_CYC = 2;
    localparam int MAXC       = 3000;
`ifdef OR_SCHED_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N_REQ-1:0] req, req_a, req_b, gnt, done;
    logic             res, busy, ga, gb, gy, err;
    bit               force_y0;

    // External gate: a plain OR, optionally stuck at 0 to provoke a self-check error.
    assign gy = force_y0 ? 1'b0 : (ga | gb);

    always #5 clk = ~clk;

    or_gate_rr_sched #(.N_REQ(N_REQ), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .req_a_i  (req_a),
        .req_b_i  (req_b),
        .gnt_o    (gnt),
        .done_o   (done),
        .res_o    (res),
        .busy_o   (busy),
        .gate_a_o (ga),
        .gate_b_o (gb),
        .gate_y_i (gy),
        .err_o    (err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit auto_en, do_rst;
    int ptr_m, next_idle;

    logic [N_REQ-1:0] exp_gnt  [MAXC];
    logic [N_REQ-1:0] exp_done [MAXC];
    bit exp_busy [MAXC];
    bit upd_g [MAXC], v_ga [MAXC], v_gb [MAXC];
    bit upd_r [MAXC], v_r [MAXC];
    bit set_e [MAXC], clr_e [MAXC];
    bit cur_ga, cur_gb, cur_res, cur_err;
    logic [N_REQ-1:0] inflight;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic clear_from(input int first);
        for (int k = first; k < MAXC; k++) begin
            exp_gnt[k]  = '0;
            exp_done[k] = '0;
            exp_busy[k] = 1'b0;
            upd_g[k] = 1'b0; v_ga[k] = 1'b0; v_gb[k] = 1'b0;
            upd_r[k] = 1'b0; v_r[k]  = 1'b0;
            set_e[k] = 1'b0; clr_e[k] = 1'b0;
        end
    endtask

    // One clock cycle: check outputs, move requester agents, advance the model.
    task automatic step();
        int w, d;
        if (upd_g[cyc]) begin cur_ga = v_ga[cyc]; cur_gb = v_gb[cyc]; end
        if (upd_r[cyc]) cur_res = v_r[cyc];
        if (clr_e[cyc]) cur_err = 1'b0;
        if (set_e[cyc]) cur_err = 1'b1;
        chk("gnt",    32'(gnt),  32'(exp_gnt[cyc]));
        chk("done",   32'(done), 32'(exp_done[cyc]));
        chk("busy",   32'(busy), 32'(exp_busy[cyc]));
        chk("gate_a", 32'(ga),   32'(cur_ga));
        chk("gate_b", 32'(gb),   32'(cur_gb));
        chk("res",    32'(res),  32'(cur_res));
        chk("err",    32'(err),  32'(cur_err));

        for (int i = 0; i < N_REQ; i++) begin
            if (exp_done[cyc][i]) inflight[i] = 1'b0;
            if (exp_gnt[cyc][i]) begin
                req[i]      = 1'b0;
                inflight[i] = 1'b1;
            end
            if (auto_en && !req[i]) begin
                req_a[i] = 1'($urandom);
                req_b[i] = 1'($urandom);
                if (!inflight[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            end
        end

        rst = do_rst;
        if (do_rst) begin
            clear_from(cyc + 1);
            upd_g[cyc + 1] = 1'b1;
            upd_r[cyc + 1] = 1'b1;
            clr_e[cyc + 1] = 1'b1;
            ptr_m     = 0;
            next_idle = cyc + 1;
            inflight  = '0;
        end else if (cyc >= next_idle && req != '0) begin
            w = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (w < 0 && req[(ptr_m + k) % N_REQ]) w = (ptr_m + k) % N_REQ;
            end
            exp_gnt[cyc + 1] = N_REQ'(1) << w;
            for (int k = cyc + 1; k <= cyc + SETTLE_CYC + 1; k++) exp_busy[k] = 1'b1;
            upd_g[cyc + 1] = 1'b1;
            v_ga[cyc + 1]  = req_a[w];
            v_gb[cyc + 1]  = req_b[w];
            d = cyc + SETTLE_CYC + 2;
            exp_done[d] = N_REQ'(1) << w;
            upd_r[d]    = 1'b1;
            v_r[d]      = force_y0 ? 1'b0 : (req_a[w] | req_b[w]);
            if (CHECK_EN && force_y0 && (req_a[w] | req_b[w])) set_e[d] = 1'b1;
            ptr_m     = (w + 1) % N_REQ;
            next_idle = d;
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_a = '0; req_b = '0;
        force_y0 = 1'b0; auto_en = 1'b0; do_rst = 1'b0;
        ptr_m = 0; next_idle = 0; inflight = '0;
        cur_ga = 1'b0; cur_gb = 1'b0; cur_res = 1'b0; cur_err = 1'b0;
        clear_from(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        repeat (10) step();

        req = 4'b0001; req_a = 4'b0001; req_b = 4'b0000;
        repeat (6) step();

        for (int p = 0; p < 4; p++) begin
            req[2] = 1'b1;
            req_a[2] = p[1];
            req_b[2] = p[0];
            repeat (SETTLE_CYC + 2) step();
        end
        repeat (4) step();

        do_rst = 1'b1; step(); do_rst = 1'b0;
        req = 4'b1111; req_a = 4'b0101; req_b = 4'b0011;
        repeat (20) step();

        req = 4'b0100; req_a = 4'b0100; req_b = 4'b0100;
        step();
        step();
        do_rst = 1'b1; step(); do_rst = 1'b0;
        repeat (6) step();

        if (CHECK_EN) begin
            force_y0 = 1'b1;
            req = 4'b0001; req_a = 4'b0001; req_b = 4'b0001;
            repeat (SETTLE_CYC + 2) step();
            force_y0 = 1'b0;
            req = 4'b0010; req_a = 4'b0010; req_b = 4'b0000;
            repeat (8) step();
            do_rst = 1'b1; step(); do_rst = 1'b0;
            repeat (3) step();
        end

        auto_en = 1'b1;
        repeat (1500) step();
        auto_en = 1'b0;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
